uart_tx_arbiter: RTL

Shares the single UART transmit FIFO write port (wr_uart, w_data, tx_full) between several frame-producing requesters, such as the card-state encoder and a debug/status reporter. It grants requesters in round-robin order and keeps a grant locked for a whole multi-byte frame, so frames are never interleaved on the link. A watchdog aborts a frame whose owner stalls, so one faulty requester cannot block the link. It sits between the requesters and the uart instance's write side.

---
 rtl/uart_tx_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, frame-locked sharing of one UART TX FIFO
// write port, with a watchdog that aborts frames whose owner stalls.
module uart_tx_arbiter #(
   parameter int N_REQ   = 2,
   parameter int TIMEOUT = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   grant,
   output logic               aborted,
   input  logic               tx_full,
   output logic               wr_uart,
   output logic [7:0]         w_data
);

   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    rr_q, rr_d;
   logic [IW-1:0]    own_q, own_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [WW-1:0]    wd_q, wd_d;
   logic             wr_q, wr_d;
   logic             ab_q, ab_d;
   logic [7:0]       wdat_q, wdat_d;

   logic [IW-1:0]    pick;
   logic             pick_vld;
   logic [IW-1:0]    own_nxt;
   logic             xfer;
   logic             last;
   logic             tmo;

   // Round-robin search: first active requester at or above rr_q, wrapping.
   always_comb begin
      int s;
      s        = 0;
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         s = int'(rr_q) + k;
         if (s >= N_REQ) s = s - N_REQ;
         if (req[IW'(s)]) begin
            pick     = IW'(s);
            pick_vld = 1'b1;
         end
      end
   end

   // Byte acceptance, frame end and watchdog expiry for the current owner.
   // A write still in flight blocks acceptance so tx_full is never stale.
   always_comb begin
      own_nxt = (int'(own_q) == N_REQ - 1) ? '0 : own_q + IW'(1);
      xfer    = (state_q == BUSY) && req[own_q] && !tx_full && !wr_q && !rst;
      last    = req_last[own_q];
      tmo     = (state_q == BUSY) && !xfer && (wd_q == WW'(TIMEOUT - 1));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_vld) state_d = BUSY;
         BUSY:    if ((xfer && last) || tmo) state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of grant, pointer, watchdog and the registered write port.
   always_comb begin
      rr_d    = rr_q;
      own_d   = own_q;
      grant_d = grant_q;
      wd_d    = wd_q;
      wr_d    = 1'b0;
      ab_d    = 1'b0;
      wdat_d  = wdat_q;
      unique case (state_q)
         IDLE: begin
            wd_d = '0;
            if (pick_vld) begin
               own_d       = pick;
               grant_d     = '0;
               grant_d[pick] = 1'b1;
            end
         end
         BUSY: begin
            if (xfer) begin
               wr_d   = 1'b1;
               wdat_d = req_data[{own_q, 3'b000} +: 8];
               wd_d   = '0;
               if (last) begin
                  rr_d    = own_nxt;
                  grant_d = '0;
               end
            end else if (tmo) begin
               ab_d    = 1'b1;
               rr_d    = own_nxt;
               grant_d = '0;
               wd_d    = '0;
            end else begin
               wd_d = wd_q + WW'(1);
            end
         end
         default: begin
            grant_d = '0;
            wd_d    = '0;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= '0;
         own_q   <= '0;
         grant_q <= '0;
         wd_q    <= '0;
         wr_q    <= 1'b0;
         ab_q    <= 1'b0;
         wdat_q  <= 8'h00;
      end else begin
         rr_q    <= rr_d;
         own_q   <= own_d;
         grant_q <= grant_d;
         wd_q    <= wd_d;
         wr_q    <= wr_d;
         ab_q    <= ab_d;
         wdat_q  <= wdat_d;
      end
   end

   // Accept pulse to the owner; writes are suppressed while reset is high.
   always_comb begin
      ack = '0;
      if (xfer) ack[own_q] = 1'b1;
   end

   assign grant   = grant_q;
   assign aborted = ab_q;
   assign wr_uart = wr_q && !rst;
   assign w_data  = wdat_q;

endmodule
